// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches floor calls, picks the next target with
// SCAN ordering, issues move commands over valid/ready, and runs the door
// dwell timer.
// Optional feature macro: DOOR_HOLD_EN (adds the door_hold input, which keeps
// the door open while it is high).
module elevator_call_scheduler #(
  parameter int unsigned NUM_FLOORS = 3,
  parameter int unsigned DOOR_TICKS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_FLOORS-1:0] interior_panel,
  input  logic [NUM_FLOORS-1:0] exterior_panel,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [2:0]            cmd_floor,
  output logic                  cmd_dir,
  input  logic                  arr_valid,
  input  logic [2:0]            arr_floor,
`ifdef DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [NUM_FLOORS-1:0] doors,
  output logic [2:0]            cur_floor,
  output logic                  dir,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  fault
);

  localparam int unsigned FW = 3;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISPATCH  = 2'd1,
    MOVING    = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FW-1:0]         cur_floor_q, cur_floor_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] doors_q, doors_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [FW-1:0]         cmd_floor_q, cmd_floor_d;
  logic                  cmd_dir_q, cmd_dir_d;
  logic                  fault_q, fault_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  busy_q, busy_d;

  logic [NUM_FLOORS-1:0] calls;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] arr_mask;
  logic                  arr_in_range;
  logic                  up_found, dn_found;
  logic [FW-1:0]         up_tgt, dn_tgt;
  logic [FW-1:0]         tgt_floor;
  logic                  tgt_dir;
  logic                  dwell_hold;

  // Decode call inputs and floor masks
  always_comb begin
    calls        = interior_panel | exterior_panel;
    cur_mask     = NUM_FLOORS'(1) << cur_floor_q;
    arr_in_range = (32'(arr_floor) < NUM_FLOORS);
    arr_mask     = arr_in_range ? (NUM_FLOORS'(1) << arr_floor) : '0;
`ifdef DOOR_HOLD_EN
    dwell_hold   = (|(calls & cur_mask)) | door_hold;
`else
    dwell_hold   = |(calls & cur_mask);
`endif
  end

  // SCAN target: nearest pending floor beyond cur_floor in dir, else reverse
  always_comb begin
    up_found  = 1'b0;
    up_tgt    = '0;
    dn_found  = 1'b0;
    dn_tgt    = '0;
    tgt_floor = '0;
    tgt_dir   = dir_q;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending_q[i] && (FW'(i) > cur_floor_q)) begin
        up_found = 1'b1;
        up_tgt   = FW'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending_q[i] && (FW'(i) < cur_floor_q)) begin
        dn_found = 1'b1;
        dn_tgt   = FW'(i);
      end
    end
    if (dir_q) begin
      if (up_found) begin
        tgt_floor = up_tgt;
        tgt_dir   = 1'b1;
      end else begin
        tgt_floor = dn_tgt;
        tgt_dir   = 1'b0;
      end
    end else begin
      if (dn_found) begin
        tgt_floor = dn_tgt;
        tgt_dir   = 1'b0;
      end else begin
        tgt_floor = up_tgt;
        tgt_dir   = 1'b1;
      end
    end
  end

  // Next-state and register-input logic; clears are applied after sets
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | calls;
    cur_floor_d = cur_floor_q;
    dir_d       = dir_q;
    doors_d     = doors_q;
    cmd_valid_d = cmd_valid_q;
    cmd_floor_d = cmd_floor_q;
    cmd_dir_d   = cmd_dir_q;
    fault_d     = fault_q;
    timer_d     = timer_q;

    unique case (state_q)
      IDLE: begin
        if (|(pending_q & cur_mask)) begin
          state_d   = DOOR_OPEN;
          pending_d = pending_d & ~cur_mask;
          timer_d   = TW'(DOOR_TICKS);
          doors_d   = cur_mask;
        end else if (|pending_q) begin
          state_d     = DISPATCH;
          cmd_valid_d = 1'b1;
          cmd_floor_d = tgt_floor;
          cmd_dir_d   = tgt_dir;
          dir_d       = tgt_dir;
        end
      end
      DISPATCH: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = MOVING;
        end
      end
      MOVING: begin
        if (arr_valid) begin
          state_d   = DOOR_OPEN;
          timer_d   = TW'(DOOR_TICKS);
          doors_d   = arr_mask;
          pending_d = pending_d & ~arr_mask;
          if (arr_in_range) begin
            cur_floor_d = arr_floor;
          end
          if (!arr_in_range || (arr_floor != cmd_floor_q)) begin
            fault_d = 1'b1;
          end
        end
      end
      DOOR_OPEN: begin
        pending_d = pending_d & ~cur_mask;
        if (dwell_hold) begin
          timer_d = TW'(DOOR_TICKS);
        end else if (timer_q <= TW'(1)) begin
          timer_d = '0;
          doors_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      cur_floor_q <= '0;
      dir_q       <= 1'b1;
      doors_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_floor_q <= '0;
      cmd_dir_q   <= 1'b1;
      fault_q     <= 1'b0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cur_floor_q <= cur_floor_d;
      dir_q       <= dir_d;
      doors_q     <= doors_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_floor_q <= cmd_floor_d;
      cmd_dir_q   <= cmd_dir_d;
      fault_q     <= fault_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_floor = cmd_floor_q;
  assign cmd_dir   = cmd_dir_q;
  assign doors     = doors_q;
  assign cur_floor = cur_floor_q;
  assign dir       = dir_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler (3 floors, 4-cycle dwell).
module tb_elevator_call_scheduler;

  localparam int unsigned NF = 3;
  localparam int unsigned DT = 4;

  typedef struct packed {
    logic [2:0] floor;
    logic       dir;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  mask;
    logic [31:0] len;
  } door_t;

  logic          CLK;
  logic          RST;
  logic [NF-1:0] interior_panel;
  logic [NF-1:0] exterior_panel;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_floor;
  logic          cmd_dir;
  logic          arr_valid;
  logic [2:0]    arr_floor;
  logic [NF-1:0] doors;
  logic [2:0]    cur_floor;
  logic          dir;
  logic [NF-1:0] pending;
  logic          busy;
  logic          fault;

  int checks   = 0;
  int failures = 0;

  cmd_t  cmd_q[$];
  door_t door_q[$];
  int    door_len = 0;
  logic [2:0] door_mask = '0;

  elevator_call_scheduler #(
    .NUM_FLOORS(NF),
    .DOOR_TICKS(DT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .interior_panel(interior_panel),
    .exterior_panel(exterior_panel),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_floor(cmd_floor),
    .cmd_dir(cmd_dir),
    .arr_valid(arr_valid),
    .arr_floor(arr_floor),
`ifdef DOOR_HOLD_EN
    .door_hold(1'b0),
`endif
    .doors(doors),
    .cur_floor(cur_floor),
    .dir(dir),
    .pending(pending),
    .busy(busy),
    .fault(fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected commands on handshakes and door episodes on close
  always @(negedge CLK) begin
    if (RST) begin
      door_len = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'(cmd_floor), 32'hFFFF);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          check("cmd_floor", 32'(cmd_floor), 32'(e.floor));
          check("cmd_dir", 32'(cmd_dir), 32'(e.dir));
        end
      end
      if (doors != '0) begin
        if (door_len == 0) door_mask = doors;
        door_len++;
      end else if (door_len != 0) begin
        if (door_q.size() == 0) begin
          check("unexpected_door", 32'(door_mask), 32'hFFFF);
        end else begin
          door_t d;
          d = door_q.pop_front();
          check("door_mask", 32'(door_mask), 32'(d.mask));
          check("door_len", 32'(door_len), d.len);
        end
        door_len = 0;
      end
    end
  end

  task automatic press(input logic [NF-1:0] im, input logic [NF-1:0] em);
    @(posedge CLK); #1;
    interior_panel = im;
    exterior_panel = em;
    @(posedge CLK); #1;
    interior_panel = '0;
    exterior_panel = '0;
  endtask

  // Returns just after the handshake edge
  task automatic wait_cmd_hs();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (cmd_valid && cmd_ready) seen = 1'b1;
    end
    check("cmd_handshake_timeout", 32'(seen), 32'd1);
    @(posedge CLK);
  endtask

  // Called right after a clock edge: one-cycle arrival pulse
  task automatic arrive(input logic [2:0] f);
    #1;
    arr_valid = 1'b1;
    arr_floor = f;
    @(posedge CLK); #1;
    arr_valid = 1'b0;
    arr_floor = '0;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (!busy) seen = 1'b1;
    end
    check("idle_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_doors_open();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (doors != '0) seen = 1'b1;
    end
    check("door_open_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    interior_panel = '0;
    exterior_panel = '0;
    cmd_ready = 1'b1;
    arr_valid = 1'b0;
    arr_floor = '0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_floor", 32'(cmd_floor), 32'd0);
    check("rst_cmd_dir", 32'(cmd_dir), 32'd1);
    check("rst_doors", 32'(doors), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cur_floor", 32'(cur_floor), 32'd0);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // Hall call to floor 2: latency, dispatch, 4-cycle dwell
    cmd_q.push_back('{3'd2, 1'b1});
    door_q.push_back('{3'b100, 32'd4});
    press('0, 3'b100);
    @(negedge CLK);
    check("lat_pending", 32'(pending), 32'b100);
    check("lat_cmd_valid_early", 32'(cmd_valid), 32'd0);
    @(negedge CLK);
    check("lat_cmd_valid", 32'(cmd_valid), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    @(posedge CLK);
    arrive(3'd2);
    wait_idle();
    check("t1_pending", 32'(pending), 32'd0);
    check("t1_doors", 32'(doors), 32'd0);
    check("t1_cur_floor", 32'(cur_floor), 32'd2);

    // Top floor going up with only a lower call: direction flips down
    cmd_q.push_back('{3'd0, 1'b0});
    door_q.push_back('{3'b001, 32'd4});
    press(3'b001, '0);
    wait_cmd_hs();
    check("top_flip_dir", 32'(dir), 32'd0);
    arrive(3'd0);
    wait_idle();
    check("c_cur_floor", 32'(cur_floor), 32'd0);

    // Floor 0 going down with only a higher call: direction flips up
    cmd_q.push_back('{3'd1, 1'b1});
    door_q.push_back('{3'b010, 32'd4});
    press('0, 3'b010);
    wait_cmd_hs();
    check("bot_flip_dir", 32'(dir), 32'd1);
    arrive(3'd1);
    wait_idle();
    check("d_cur_floor", 32'(cur_floor), 32'd1);

    // Floor 1 going up, only floor 0 pending; stall cmd_ready 5 cycles
    #1 cmd_ready = 1'b0;
    cmd_q.push_back('{3'd0, 1'b0});
    press(3'b001, '0);
    @(posedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_cmd_valid", 32'(cmd_valid), 32'd1);
      check("stall_cmd_floor", 32'(cmd_floor), 32'd0);
      check("stall_cmd_dir", 32'(cmd_dir), 32'd0);
      if (i == 1) begin #1 interior_panel = 3'b100; end
      if (i == 2) begin #1 interior_panel = '0; end
    end
    @(posedge CLK); #1;
    cmd_ready = 1'b1;
    wait_cmd_hs();
    check("mid_flip_dir", 32'(dir), 32'd0);
    door_q.push_back('{3'b001, 32'd4});
    cmd_q.push_back('{3'd2, 1'b1});
    arrive(3'd0);
    wait_idle();
    check("stall_pending_kept", 32'(pending), 32'b100);
    wait_cmd_hs();
    door_q.push_back('{3'b100, 32'd4});
    arrive(3'd2);
    wait_idle();

    // Same-floor call at timer=1 reloads the dwell
    door_q.push_back('{3'b100, 32'd8});
    press(3'b100, '0);
    wait_doors_open();
    repeat (3) @(posedge CLK);
    #1 interior_panel = 3'b100;
    @(posedge CLK); #1;
    interior_panel = '0;
    @(negedge CLK);
    check("reload_pending", 32'(pending), 32'd0);
    wait_idle();
    check("f_pending", 32'(pending), 32'd0);
    check("f_cur_floor", 32'(cur_floor), 32'd2);

    // Wrong-floor arrival: fault, cur_floor follows arrival, re-dispatch
    cmd_q.push_back('{3'd0, 1'b0});
    press('0, 3'b001);
    wait_cmd_hs();
    door_q.push_back('{3'b010, 32'd4});
    cmd_q.push_back('{3'd0, 1'b0});
    arrive(3'd1);
    @(negedge CLK);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_cur_floor", 32'(cur_floor), 32'd1);
    check("mis_pending", 32'(pending), 32'b001);
    wait_cmd_hs();
    door_q.push_back('{3'b001, 32'd4});
    arrive(3'd0);
    wait_idle();
    check("mis_fault_sticky", 32'(fault), 32'd1);
    check("g_cur_floor", 32'(cur_floor), 32'd0);

    // Out-of-range arrival: cur_floor unchanged, doors stay closed
    cmd_q.push_back('{3'd2, 1'b1});
    press('0, 3'b100);
    wait_cmd_hs();
    cmd_q.push_back('{3'd2, 1'b1});
    arrive(3'd3);
    @(negedge CLK);
    check("oor_cur_floor", 32'(cur_floor), 32'd0);
    check("oor_doors", 32'(doors), 32'd0);
    check("oor_busy", 32'(busy), 32'd1);
    wait_cmd_hs();
    door_q.push_back('{3'b100, 32'd4});
    arrive(3'd2);
    wait_idle();
    check("oor_end_floor", 32'(cur_floor), 32'd2);

    // Asynchronous reset while MOVING
    cmd_q.push_back('{3'd0, 1'b0});
    press('0, 3'b001);
    wait_cmd_hs();
    #3 RST = 1'b1;
    #1;
    check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("arst_doors", 32'(doors), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_cur_floor", 32'(cur_floor), 32'd0);
    check("arst_dir", 32'(dir), 32'd1);
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge CLK); #2;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("door_q_drained", 32'(door_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
